// File: rtl/sa_rdata_router.sv
// Read-data return path: 2-entry skid buffer on the slave R channel, routing to masters by
// the upper RID bits, and RLAST suppression for bursts the address path split into sub-bursts.
module sa_rdata_router #(
    parameter int MST_AMT         = 3,
    parameter int MST_ID_W        = $clog2(MST_AMT),
    parameter int OUTSTANDING_AMT = 8,
    parameter int SPLIT_W         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W
) (
    input  logic                                ACLK_i,
    input  logic                                ARESETn_i,
    input  logic [TRANS_SLV_ID_W-1:0]           s_RID_i,
    input  logic [DATA_WIDTH-1:0]               s_RDATA_i,
    input  logic                                s_RLAST_i,
    input  logic                                s_RVALID_i,
    output logic                                s_RREADY_o,
    input  logic [TRANS_SLV_ID_W-1:0]           AR_AxID_i,
    input  logic [SPLIT_W-1:0]                  AR_split_num_i,
    input  logic                                AR_shift_en_i,
    output logic                                AR_stall_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_RID_o,
    output logic [DATA_WIDTH*MST_AMT-1:0]       dsp_RDATA_o,
    output logic [MST_AMT-1:0]                  dsp_RLAST_o,
    output logic [MST_AMT-1:0]                  dsp_RVALID_o,
    input  logic [MST_AMT-1:0]                  dsp_RREADY_i
);
    localparam int SF_AW = $clog2(OUTSTANDING_AMT);
    localparam logic [SF_AW:0] SF_DEPTH = (SF_AW+1)'(OUTSTANDING_AMT);

    typedef struct packed {
        logic [TRANS_SLV_ID_W-1:0] id;
        logic [DATA_WIDTH-1:0]     data;
        logic                      last;
    } beat_t;

    typedef struct packed {
        logic [TRANS_SLV_ID_W-1:0] id;
        logic [SPLIT_W-1:0]        num;
    } split_t;

    beat_t              buf_q [2];
    beat_t              buf_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         buf_cnt_q, buf_cnt_d;
    logic               s_rready_q, s_rready_d;

    split_t             sf_mem_q [OUTSTANDING_AMT];
    split_t             sf_mem_d [OUTSTANDING_AMT];
    logic [SF_AW-1:0]   sf_wr_q, sf_wr_d;
    logic [SF_AW-1:0]   sf_rd_q, sf_rd_d;
    logic [SF_AW:0]     sf_cnt_q, sf_cnt_d;
    logic [SPLIT_W-1:0] split_cnt_q, split_cnt_d;

    beat_t              head;
    split_t             sf_head;
    logic [MST_ID_W-1:0] h_mst;
    logic [MST_AMT-1:0] rvalid;
    logic               head_vld, route_ok, r_push, r_pop;
    logic               filt, last_pop, split_done, sf_wr, sf_full, sf_empty;

    assign head     = buf_q[rd_ptr_q];
    assign h_mst    = head.id[TRANS_SLV_ID_W-1 -: MST_ID_W];
    assign head_vld = (buf_cnt_q != 2'd0);
    assign route_ok = (32'(h_mst) < MST_AMT);

    assign sf_head  = sf_mem_q[sf_rd_q];
    assign sf_full  = (sf_cnt_q == SF_DEPTH);
    assign sf_empty = (sf_cnt_q == '0);

    always_comb begin
        rvalid = '0;
        for (int m = 0; m < MST_AMT; m++) begin
            rvalid[m] = head_vld && (32'(h_mst) == m);
        end
    end

    // Unroutable heads are discarded in their first valid cycle so they cannot block the path.
    assign r_push = s_RVALID_i & s_rready_q;
    assign r_pop  = head_vld & (~route_ok | (|(rvalid & dsp_RREADY_i)));

    assign filt       = ~sf_empty & (sf_head.id == head.id);
    assign last_pop   = r_pop & head.last & filt;
    assign split_done = last_pop & (split_cnt_q == sf_head.num - SPLIT_W'(1));
    // A full FIFO still accepts a write when the same edge retires its head.
    assign sf_wr      = AR_shift_en_i & (AR_split_num_i != '0) & (~sf_full | split_done);

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (r_push) begin
            buf_d[wr_ptr_q] = '{id: s_RID_i, data: s_RDATA_i, last: s_RLAST_i};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (r_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        buf_cnt_d  = buf_cnt_q + {1'b0, r_push} - {1'b0, r_pop};
        s_rready_d = (buf_cnt_d != 2'd2);
    end

    always_comb begin
        sf_mem_d = sf_mem_q;
        sf_wr_d  = sf_wr_q;
        sf_rd_d  = sf_rd_q;
        if (sf_wr) begin
            sf_mem_d[sf_wr_q] = '{id: AR_AxID_i, num: AR_split_num_i};
            sf_wr_d           = sf_wr_q + SF_AW'(1);
        end
        if (split_done) begin
            sf_rd_d = sf_rd_q + SF_AW'(1);
        end
        sf_cnt_d = sf_cnt_q + {{SF_AW{1'b0}}, sf_wr} - {{SF_AW{1'b0}}, split_done};

        split_cnt_d = split_cnt_q;
        if (last_pop) begin
            split_cnt_d = split_done ? '0 : split_cnt_q + SPLIT_W'(1);
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            for (int i = 0; i < OUTSTANDING_AMT; i++) begin
                sf_mem_q[i] <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
            s_rready_q  <= 1'b1;
            sf_wr_q     <= '0;
            sf_rd_q     <= '0;
            sf_cnt_q    <= '0;
            split_cnt_q <= '0;
        end else begin
            buf_q       <= buf_d;
            sf_mem_q    <= sf_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_cnt_q   <= buf_cnt_d;
            s_rready_q  <= s_rready_d;
            sf_wr_q     <= sf_wr_d;
            sf_rd_q     <= sf_rd_d;
            sf_cnt_q    <= sf_cnt_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    assign s_RREADY_o   = s_rready_q;
    assign AR_stall_o   = sf_full;
    assign dsp_RVALID_o = rvalid;
    assign dsp_RID_o    = {MST_AMT{head.id[TRANS_MST_ID_W-1:0]}};
    assign dsp_RDATA_o  = {MST_AMT{head.data}};
    assign dsp_RLAST_o  = {MST_AMT{head.last & ~filt}};

endmodule

// File: tb/tb_sa_rdata_router.sv
// Bench for sa_rdata_router: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue-based model of beats and pending split bursts.
module tb_sa_rdata_router;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  s_rid = '0;
    logic [31:0] s_rdata = '0;
    logic        s_rlast = 1'b0;
    logic        s_rvalid = 1'b0;
    logic        s_rready;
    logic [6:0]  ar_id = '0;
    logic [1:0]  ar_split = '0;
    logic        ar_en = 1'b0;
    logic        ar_stall;
    logic [14:0] d_rid;
    logic [95:0] d_rdata;
    logic [2:0]  d_rlast;
    logic [2:0]  d_rvalid;
    logic [2:0]  m_ready = 3'b111;

    sa_rdata_router dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .s_RID_i(s_rid), .s_RDATA_i(s_rdata), .s_RLAST_i(s_rlast),
        .s_RVALID_i(s_rvalid), .s_RREADY_o(s_rready),
        .AR_AxID_i(ar_id), .AR_split_num_i(ar_split), .AR_shift_en_i(ar_en),
        .AR_stall_o(ar_stall),
        .dsp_RID_o(d_rid), .dsp_RDATA_o(d_rdata), .dsp_RLAST_o(d_rlast),
        .dsp_RVALID_o(d_rvalid), .dsp_RREADY_i(m_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int beats_seen = 0;
    int lasts_seen = 0;

    // Model state: beats held by the router as {id, data, last}, and split bursts still owed
    // suppressed RLASTs (id plus number of RLASTs left to swallow).
    logic [39:0] exp_q[$];
    logic [6:0]  sq_id[$];
    int          sq_left[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            sq_id.delete();
            sq_left.delete();
        end else begin
            logic [39:0] hd;
            logic [2:0]  ev;
            int          hm;
            logic        match;
            ev    = '0;
            hm    = 0;
            match = 1'b0;
            hd    = '0;
            if (exp_q.size() > 0) begin
                hd = exp_q[0];
                hm = int'(hd[39:38]);
                if (hm < 3) ev[hm] = 1'b1;
                match = (sq_id.size() > 0) && (sq_id[0] == hd[39:33]);
            end
            chk("mon_sready", s_rready, exp_q.size() < 2);
            chk("mon_stall", ar_stall, sq_id.size() == 8);
            chk("mon_rvalid", d_rvalid, ev);
            if (ev != 0) begin
                chk("mon_rid", d_rid[hm*5 +: 5], hd[37:33]);
                chk("mon_rdata", d_rdata[hm*32 +: 32], hd[32:1]);
                chk("mon_rlast", d_rlast[hm], hd[0] & ~match);
            end
            if (exp_q.size() > 0 && (hm == 3 || m_ready[hm])) begin
                if (hm < 3) begin
                    beats_seen++;
                    if (hd[0] && !match) lasts_seen++;
                end
                if (hd[0] && match) begin
                    sq_left[0] = sq_left[0] - 1;
                    if (sq_left[0] == 0) begin
                        void'(sq_id.pop_front());
                        void'(sq_left.pop_front());
                    end
                end
                void'(exp_q.pop_front());
            end
            if (ar_en && ar_split != 0 && sq_id.size() < 8) begin
                sq_id.push_back(ar_id);
                sq_left.push_back(int'(ar_split));
            end
            if (s_rvalid && s_rready) exp_q.push_back({s_rid, s_rdata, s_rlast});
        end
    end

    typedef struct {
        logic        ar_en;
        logic [6:0]  ar_id;
        logic [1:0]  ar_sp;
        logic        rv;
        logic [6:0]  rid;
        logic [31:0] rdata;
        logic        rlast;
        logic [2:0]  exp_valid;
        logic [4:0]  exp_id;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    function automatic vec_t mkv(logic ae, logic [6:0] aid, logic [1:0] asp, logic rv,
                                 logic [6:0] rid, logic [31:0] rd, logic rl,
                                 logic [2:0] ev, logic [4:0] eid, logic [31:0] ed, logic el);
        vec_t v;
        v.ar_en = ae; v.ar_id = aid; v.ar_sp = asp;
        v.rv = rv; v.rid = rid; v.rdata = rd; v.rlast = rl;
        v.exp_valid = ev; v.exp_id = eid; v.exp_data = ed; v.exp_last = el;
        return v;
    endfunction

    function automatic int oh_idx(logic [2:0] v);
        return v[0] ? 0 : (v[1] ? 1 : 2);
    endfunction

    task automatic idle_inputs();
        s_rvalid = 1'b0; s_rlast = 1'b0; ar_en = 1'b0; ar_split = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_burst(input logic [6:0] id, input int n, input logic [31:0] base);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 100) begin
            @(posedge clk); #1;
            s_rvalid = 1'b1; s_rid = id; s_rdata = base + i; s_rlast = (i == n - 1);
            @(negedge clk);
            if (s_rready) i++;
            guard++;
        end
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0;
        chk("burst_accept", i, n);
    endtask

    task automatic ar_issue(input logic [6:0] id, input logic [1:0] sp);
        @(posedge clk); #1;
        ar_en = 1'b1; ar_id = id; ar_split = sp;
        @(posedge clk); #1;
        ar_en = 1'b0; ar_split = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t tbl [15];

    initial begin
        // Unsplit burst to master 1 (RID {1,3}), then a burst split into 3 sub-bursts for master 0.
        tbl[0]  = mkv(0, 0, 0, 1, 7'h23, 32'hA0, 0, 3'b000, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 1, 7'h23, 32'hA1, 0, 3'b010, 3, 32'hA0, 0);
        tbl[2]  = mkv(0, 0, 0, 1, 7'h23, 32'hA2, 0, 3'b010, 3, 32'hA1, 0);
        tbl[3]  = mkv(0, 0, 0, 1, 7'h23, 32'hA3, 1, 3'b010, 3, 32'hA2, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 7'h00, 32'h00, 0, 3'b010, 3, 32'hA3, 1);
        tbl[5]  = mkv(0, 0, 0, 0, 7'h00, 32'h00, 0, 3'b000, 0, 0, 0);
        tbl[6]  = mkv(1, 7'h07, 2, 0, 7'h00, 32'h00, 0, 3'b000, 0, 0, 0);
        tbl[7]  = mkv(0, 0, 0, 1, 7'h07, 32'hB0, 0, 3'b000, 0, 0, 0);
        tbl[8]  = mkv(0, 0, 0, 1, 7'h07, 32'hB1, 1, 3'b001, 7, 32'hB0, 0);
        tbl[9]  = mkv(0, 0, 0, 1, 7'h07, 32'hB2, 0, 3'b001, 7, 32'hB1, 0);
        tbl[10] = mkv(0, 0, 0, 1, 7'h07, 32'hB3, 1, 3'b001, 7, 32'hB2, 0);
        tbl[11] = mkv(0, 0, 0, 1, 7'h07, 32'hB4, 0, 3'b001, 7, 32'hB3, 0);
        tbl[12] = mkv(0, 0, 0, 1, 7'h07, 32'hB5, 1, 3'b001, 7, 32'hB4, 0);
        tbl[13] = mkv(0, 0, 0, 0, 7'h00, 32'h00, 0, 3'b001, 7, 32'hB5, 1);
        tbl[14] = mkv(0, 0, 0, 0, 7'h00, 32'h00, 0, 3'b000, 0, 0, 0);

        @(negedge clk);
        chk("rst_rvalid", d_rvalid, 3'b000);
        chk("rst_sready", s_rready, 1'b1);
        chk("rst_stall", ar_stall, 1'b0);
        chk("rst_rid", d_rid, 15'h0);
        chk("rst_rdata", d_rdata, 96'h0);
        chk("rst_rlast", d_rlast, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            ar_en = tbl[i].ar_en; ar_id = tbl[i].ar_id; ar_split = tbl[i].ar_sp;
            s_rvalid = tbl[i].rv; s_rid = tbl[i].rid; s_rdata = tbl[i].rdata; s_rlast = tbl[i].rlast;
            @(negedge clk);
            chk("tbl_rvalid", d_rvalid, tbl[i].exp_valid);
            chk("tbl_sready", s_rready, 1'b1);
            chk("tbl_stall", ar_stall, 1'b0);
            if (tbl[i].exp_valid != 0) begin
                chk("tbl_rid", d_rid[oh_idx(tbl[i].exp_valid)*5 +: 5], tbl[i].exp_id);
                chk("tbl_rdata", d_rdata[oh_idx(tbl[i].exp_valid)*32 +: 32], tbl[i].exp_data);
                chk("tbl_rlast", d_rlast[oh_idx(tbl[i].exp_valid)], tbl[i].exp_last);
            end
        end
        @(posedge clk); #1;
        idle_inputs();

        // Back-pressure: master 2 stalls for 5 cycles while a 6-beat burst streams in.
        begin
            int bi = 0;
            beats_seen = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(posedge clk); #1;
                m_ready[2] = (cyc >= 5);
                s_rvalid = (bi < 6); s_rid = 7'h41; s_rdata = 32'hC0 + bi; s_rlast = (bi == 5);
                @(negedge clk);
                if (cyc == 2) chk("bp_sready_low", s_rready, 1'b0);
                if (s_rvalid && s_rready) bi++;
            end
            @(posedge clk); #1;
            idle_inputs();
            wait_cycles(3);
            chk("bp_accepted", bi, 6);
            chk("bp_delivered", beats_seen, 6);
            chk("bp_drained", exp_q.size(), 0);
        end

        // Interleaved IDs: head entry A split once, an unrelated burst B arrives first.
        beats_seen = 0; lasts_seen = 0;
        ar_issue(7'h04, 2'd1);
        send_burst(7'h05, 2, 32'hD0);
        send_burst(7'h04, 1, 32'hD8);
        send_burst(7'h04, 1, 32'hD9);
        wait_cycles(4);
        chk("il_beats", beats_seen, 4);
        chk("il_lasts", lasts_seen, 2);
        chk("il_fifo_empty", sq_id.size(), 0);

        // Split FIFO fill: eight back-to-back split ARs with no R traffic.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            ar_en = 1'b1; ar_id = 7'h20 + 7'(k); ar_split = 2'd1;
            @(negedge clk);
            chk("full_stall_low", ar_stall, 1'b0);
        end
        @(posedge clk); #1;
        ar_en = 1'b0; ar_split = '0;
        @(negedge clk);
        chk("full_stall_high", ar_stall, 1'b1);
        lasts_seen = 0;
        send_burst(7'h20, 1, 32'hE0);
        begin
            int w = 0;
            while (ar_stall && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk("full_stall_fall", ar_stall, 1'b0);
        end
        send_burst(7'h20, 1, 32'hE1);
        wait_cycles(3);
        chk("full_lasts", lasts_seen, 1);
        do_reset();

        // Reset with two beats buffered and three split entries pending.
        ar_issue(7'h03, 2'd1);
        ar_issue(7'h03, 2'd2);
        ar_issue(7'h06, 2'd1);
        m_ready = 3'b000;
        send_burst(7'h21, 2, 32'hF0);
        @(negedge clk);
        chk("pre_rst_sready", s_rready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", d_rvalid, 3'b000);
        chk("mid_rst_sready", s_rready, 1'b1);
        chk("mid_rst_stall", ar_stall, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 3'b111;
        lasts_seen = 0; beats_seen = 0;
        send_burst(7'h03, 3, 32'h10);
        wait_cycles(3);
        chk("post_rst_beats", beats_seen, 3);
        chk("post_rst_lasts", lasts_seen, 1);

        // Randomized traffic with a small ID pool so split entries regularly match.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            s_rvalid = ($urandom_range(0, 3) != 0);
            s_rid    = {2'($urandom_range(0, 3)), 5'($urandom_range(0, 1))};
            s_rdata  = $urandom;
            s_rlast  = ($urandom_range(0, 2) == 0);
            ar_en    = ($urandom_range(0, 5) == 0);
            ar_id    = {2'($urandom_range(0, 2)), 5'($urandom_range(0, 1))};
            ar_split = 2'($urandom_range(0, 3));
            m_ready  = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        idle_inputs();
        m_ready = 3'b111;
        wait_cycles(5);
        chk("rand_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
